ads_ch_arbiter: RTL and testbench

- Round-robin scheduler that merges the per-channel sample strobes of both ADS acquisition chains into one tagged sample stream.
- Covers Ch0..Ch3 of ads1 (channels 0..3) and Ch0..Ch3 of ads2 (channels 4..7).
- Sits between the acquisition/decimation outputs and the single downstream consumer (packet builder / FIFO writer).
- Each channel has a 1-deep holding register; the output is a valid/ready register slice.

---
 rtl/ads_ch_arbiter.sv | 143 ++++++++++++++
 tb/tb_ads_ch_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ads_ch_arbiter.sv
// Round-robin merge of per-channel ADS sample strobes into one tagged valid/ready stream.
// Optional per-channel saturating drop counters are enabled by defining ADS_ARB_OVF_CNT_EN.
module ads_ch_arbiter #(
   parameter int NCH = 8,
   parameter int DW  = 16,
   parameter int TW  = 4
) (
   input  logic              clk,
   input  logic              RESETN,
   input  logic [NCH*DW-1:0] ch_data,
   input  logic [NCH-1:0]    ch_en,
   input  logic [NCH-1:0]    ch_mask,
   input  logic              ovf_clr,
   output logic [DW-1:0]     out_data,
   output logic [TW-1:0]     out_ch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NCH-1:0]    pend,
   output logic [NCH-1:0]    ovf
`ifdef ADS_ARB_OVF_CNT_EN
   ,
   output logic [NCH*8-1:0]  ovf_cnt
`endif
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_t;

   slot_t            slot_q, slot_d;
   logic [DW-1:0]    hold_q [NCH];
   logic [DW-1:0]    hold_d [NCH];
   logic [NCH-1:0]   pend_q, pend_d, ovf_q, ovf_d;
   logic [NCH-1:0]   cap, accept, drop, gnt_oh;
   logic [DW-1:0]    out_data_q, out_data_d, gnt_data;
   logic [TW-1:0]    out_ch_q, out_ch_d, last_q, last_d, gnt_idx;
   logic             slot_free, gnt_found, grant;

   assign cap       = ch_en & ch_mask;
   assign slot_free = (slot_q == S_EMPTY) || out_ready;

   // Scan downward so the last hit is the channel closest after last_q.
   always_comb begin : rr_search
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_data  = '0;
      for (int k = NCH; k >= 1; k--) begin
         idx = (int'(last_q) + k) % NCH;
         if (pend_q[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = TW'(idx);
            gnt_data  = hold_q[idx];
         end
      end
   end

   assign grant  = slot_free & gnt_found;
   assign gnt_oh = grant ? (NCH'(1) << gnt_idx) : '0;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      // A channel being granted this cycle frees its holding register for a same-cycle capture.
      assign accept[gi] = cap[gi] & (~pend_q[gi] | gnt_oh[gi]);
      assign drop[gi]   = cap[gi] & pend_q[gi] & ~gnt_oh[gi];
      assign pend_d[gi] = accept[gi] | (pend_q[gi] & ~gnt_oh[gi]);
      assign ovf_d[gi]  = drop[gi] | (ovf_q[gi] & ~ovf_clr);
      assign hold_d[gi] = accept[gi] ? ch_data[gi*DW +: DW] : hold_q[gi];
   end

   always_ff @(posedge clk or negedge RESETN) begin
      if (!RESETN) begin
         slot_q     <= S_EMPTY;
         pend_q     <= '0;
         ovf_q      <= '0;
         out_data_q <= '0;
         out_ch_q   <= '0;
         last_q     <= TW'(NCH - 1);
      end else begin
         slot_q     <= slot_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
         last_q     <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   always_comb begin
      slot_d = slot_q;
      if (grant) begin
         slot_d = S_FULL;
      end else if (slot_free) begin
         slot_d = S_EMPTY;
      end
   end

   always_comb begin
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      last_d     = last_q;
      if (grant) begin
         out_data_d = gnt_data;
         out_ch_d   = gnt_idx;
         last_d     = gnt_idx;
      end
   end

   always_comb begin
      out_valid = (slot_q == S_FULL);
      out_data  = out_data_q;
      out_ch    = out_ch_q;
      pend      = pend_q;
      ovf       = ovf_q;
   end

`ifdef ADS_ARB_OVF_CNT_EN
   logic [7:0] cnt_q [NCH];
   logic [7:0] cnt_d [NCH];

   for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
      // A drop coinciding with a clear leaves a count of one.
      assign cnt_d[gi] = drop[gi] ? (ovf_clr ? 8'd1 : ((cnt_q[gi] == 8'hFF) ? 8'hFF : cnt_q[gi] + 8'd1))
                                  : (ovf_clr ? 8'd0 : cnt_q[gi]);
      assign ovf_cnt[gi*8 +: 8] = cnt_q[gi];
   end

   always_ff @(posedge clk or negedge RESETN) begin
      if (!RESETN) begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end
`endif

endmodule

// File: tb/tb_ads_ch_arbiter.sv
// Bench for ads_ch_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_ads_ch_arbiter;
   localparam int NCH = 8;
   localparam int DW  = 16;
   localparam int TW  = 4;

   logic              clk = 1'b0;
   logic              RESETN;
   logic [NCH*DW-1:0] ch_data;
   logic [NCH-1:0]    ch_en, ch_mask;
   logic              ovf_clr, out_ready;
   logic [DW-1:0]     out_data;
   logic [TW-1:0]     out_ch;
   logic              out_valid;
   logic [NCH-1:0]    pend, ovf;
`ifdef ADS_ARB_OVF_CNT_EN
   logic [NCH*8-1:0]  ovf_cnt;
`endif

   always #5 clk = ~clk;

   ads_ch_arbiter #(.NCH(NCH), .DW(DW), .TW(TW)) dut (
      .clk(clk), .RESETN(RESETN), .ch_data(ch_data), .ch_en(ch_en), .ch_mask(ch_mask),
      .ovf_clr(ovf_clr), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready), .pend(pend), .ovf(ovf)
`ifdef ADS_ARB_OVF_CNT_EN
      , .ovf_cnt(ovf_cnt)
`endif
   );

   int tests = 0;
   int fails = 0;

   // Behavioural model: what the stream must look like after each clock edge.
   bit [NCH-1:0] m_pend, m_ovf;
   bit [DW-1:0]  m_hold [NCH];
   bit           m_valid;
   bit [DW-1:0]  m_data;
   int           m_ch, m_last;
   int           m_cnt [NCH];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = NCH - 1;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
   endtask

   task automatic model_step();
      bit           free;
      int           g;
      bit [NCH-1:0] np;
      free = !m_valid || out_ready;
      g    = -1;
      if (free) begin
         for (int k = 1; k <= NCH; k++) begin
            if (g < 0 && m_pend[(m_last + k) % NCH]) g = (m_last + k) % NCH;
         end
      end
      np = m_pend;
      if (g >= 0) begin
         m_data = m_hold[g]; m_ch = g; m_valid = 1'b1; m_last = g; np[g] = 1'b0;
      end else if (free) begin
         m_valid = 1'b0;
      end
      if (ovf_clr) begin
         m_ovf = '0;
         for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      end
      for (int i = 0; i < NCH; i++) begin
         if (ch_en[i] && ch_mask[i]) begin
            if (!m_pend[i] || g == i) begin
               m_hold[i] = ch_data[i*DW +: DW];
               np[i] = 1'b1;
            end else begin
               m_ovf[i] = 1'b1;
               m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
            end
         end
      end
      m_pend = np;
   endtask

   task automatic compare();
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
         chk("out_data", out_data, m_data);
         chk("out_ch", out_ch, m_ch);
      end
      chk("pend", pend, m_pend);
      chk("ovf", ovf, m_ovf);
`ifdef ADS_ARB_OVF_CNT_EN
      for (int i = 0; i < NCH; i++) chk("ovf_cnt", ovf_cnt[i*8 +: 8], m_cnt[i]);
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      $display("[TB] t=%0t en=%02h rdy=%0b valid=%0b ch=%0d data=%04h pend=%02h ovf=%02h",
               $time, ch_en, out_ready, out_valid, out_ch, out_data, pend, ovf);
   endtask

   task automatic do_reset();
      RESETN = 1'b0; ch_en = '0; ovf_clr = 1'b0; ch_mask = '1; out_ready = 1'b1;
      #1;
      model_reset();
      @(negedge clk);
      compare();
      RESETN = 1'b1;
   endtask

   task automatic set_ch(input int ch, input logic [DW-1:0] v);
      ch_data[ch*DW +: DW] = v;
   endtask

   initial begin
      RESETN = 1'b0; ch_data = '0; ch_en = '0; ch_mask = '1; ovf_clr = 1'b0; out_ready = 1'b1;
      do_reset();
      chk("rst_valid", out_valid, 0); chk("rst_pend", pend, 0); chk("rst_ovf", ovf, 0);
      chk("rst_data", out_data, 0);   chk("rst_ch", out_ch, 0);

      // 1: single strobe, 2-cycle latency
      set_ch(0, 16'h1234); ch_en = 8'h01;
      cycle(); chk("t1_pend", pend, 8'h01); chk("t1_nv", out_valid, 0);
      ch_en = '0;
      cycle(); chk("t1_valid", out_valid, 1); chk("t1_data", out_data, 16'h1234); chk("t1_ch", out_ch, 0);
      cycle(); chk("t1_gone", out_valid, 0); chk("t1_ovf", ovf, 0);

      // 2: round-robin order
      do_reset();
      for (int i = 0; i < NCH; i++) set_ch(i, 16'(i));
      ch_en = 8'hFF; cycle(); ch_en = '0;
      for (int i = 0; i < NCH; i++) begin
         cycle(); chk("t2_valid", out_valid, 1); chk("t2_ch", out_ch, i); chk("t2_data", out_data, i);
      end
      for (int r = 0; r < 2; r++) begin
         ch_en = 8'h81; cycle(); ch_en = '0;
         cycle(); chk("t2b_ch0", out_ch, 0);
         cycle(); chk("t2b_ch7", out_ch, 7);
      end

      // 3: stall, overflow, drop
      do_reset();
      out_ready = 1'b0;
      set_ch(3, 16'hAAAA); ch_en = 8'h08; cycle();
      set_ch(3, 16'hCCCC); cycle();
      ch_en = '0; cycle(); chk("t3_hold", out_data, 16'hAAAA);
      set_ch(3, 16'hBBBB); ch_en = 8'h08; cycle();
      chk("t3_ovf", ovf[3], 1); chk("t3_hold2", out_data, 16'hAAAA);
      ch_en = '0; cycle(); chk("t3_hold3", out_data, 16'hAAAA);
      out_ready = 1'b1;
      cycle(); chk("t3_next", out_data, 16'hCCCC); chk("t3_next_ch", out_ch, 3);
      cycle(); chk("t3_empty", out_valid, 0);

      // 4: continuous strobe on ch0, then overflow racing ovf_clr
      do_reset();
      for (int n = 0; n < 10; n++) begin
         ch_en = 8'h01; set_ch(0, 16'(n + 'h100)); cycle();
         if (n >= 1) begin
            chk("t4_valid", out_valid, 1); chk("t4_data", out_data, 16'(n - 1 + 'h100));
         end
         chk("t4_noovf", ovf, 0);
      end
      out_ready = 1'b0; ovf_clr = 1'b1; cycle();
      chk("t4_setwins", ovf[0], 1);
      ch_en = '0; cycle(); chk("t4_clr", ovf, 0);
      ovf_clr = 1'b0; out_ready = 1'b1; cycle(); cycle();

      // 5: masking
      do_reset();
      ch_mask = 8'hFE; ch_en = 8'h01; cycle(); chk("t5_pend", pend, 0);
      ch_en = '0; cycle(); chk("t5_none", out_valid, 0);
      ch_mask = 8'hFF; set_ch(1, 16'h5A5A); ch_en = 8'h02; cycle();
      ch_en = '0; ch_mask = 8'hFD; cycle();
      chk("t5_valid", out_valid, 1); chk("t5_ch", out_ch, 1); chk("t5_data", out_data, 16'h5A5A);
      ch_mask = 8'hFF; cycle();

      // 6: asynchronous reset mid-transfer
      do_reset();
      out_ready = 1'b0; ch_en = 8'h0F; cycle();
      ch_en = 8'h01; cycle();
      ch_en = 8'h02; cycle();
      chk("t6_pre_pend", pend, 8'h0F); chk("t6_pre_valid", out_valid, 1); chk("t6_pre_ovf", ovf, 8'h02);
      ch_en = '0;
      #2 RESETN = 1'b0;
      #1;
      chk("t6_valid0", out_valid, 0); chk("t6_pend0", pend, 0); chk("t6_ovf0", ovf, 0);
      model_reset();
      @(negedge clk); compare();
      RESETN = 1'b1; out_ready = 1'b1;
      ch_en = 8'hFF; cycle(); ch_en = '0;
      cycle(); chk("t6_first", out_ch, 0);

      // Random traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         ch_data   = {$urandom, $urandom, $urandom, $urandom};
         ch_en     = 8'($urandom & $urandom);
         ch_mask   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
         out_ready = ($urandom_range(0, 3) != 0);
         ovf_clr   = ($urandom_range(0, 15) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
